// File: rtl/uart_tx_arbiter_if.sv
// Word-source and UartTx handshake bundle for uart_tx_arbiter.
// master drives words and tx_busy; slave is the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     tx_busy;
  logic                     tx_start;
  logic [7:0]               sdata;
  logic                     busy;
  logic [CW-1:0]            grant_ch;

  modport master (
    output in_valid, in_data, tx_busy,
    input  in_ready, tx_start, sdata,
    input  busy, grant_ch
  );

  modport slave (
    input  in_valid, in_data, tx_busy,
    output in_ready, tx_start, sdata,
    output busy, grant_ch
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Per-channel word FIFOs arbitrated onto one UartTx, LSB byte first.
// Define TX_ARB_PRIO_EN for fixed priority instead of round-robin.
module uart_tx_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [PW:0] P_ONE = (PW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_GUARD, S_WAIT
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_mem [NUM_CH][FIFO_DEPTH];
  logic [PW:0]       r_wp  [NUM_CH];
  logic [PW:0]       r_rp  [NUM_CH];

  logic [NUM_CH-1:0] w_full, w_empty;
  logic [NUM_CH-1:0] w_push, w_pop;
  logic [DATA_W-1:0] r_shift, w_shift_nx, w_head;
  logic [BW-1:0]     r_cnt;
  logic [7:0]        r_sdata;
  logic [CW-1:0]     r_grant, w_gnt;
  logic              w_gnt_vld, w_load;
  logic              w_adv, w_last;

  // full when pointers differ only in the wrap bit
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_empty[c] = (r_wp[c] == r_rp[c]);
      w_full[c]  = (r_wp[c][PW] != r_rp[c][PW]) &&
                   (r_wp[c][PW-1:0] == r_rp[c][PW-1:0]);
    end
  end

  assign w_push    = bus.in_valid & ~w_full;
  assign w_gnt_vld = ~&w_empty;

`ifdef TX_ARB_PRIO_EN
  always_comb begin
    w_gnt = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (!w_empty[j]) w_gnt = CW'(j);
    end
  end
`else
  logic [CW-1:0] r_ptr;
  int            w_best, w_rank;

  // rank 0 is the channel just after the last grant
  always_comb begin
    w_gnt  = '0;
    w_best = NUM_CH;
    w_rank = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      w_rank = (j + 2 * NUM_CH - int'(r_ptr) - 1)
               % NUM_CH;
      if (!w_empty[j] && w_rank < w_best) begin
        w_best = w_rank;
        w_gnt  = CW'(j);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       r_ptr <= CW'(NUM_CH - 1);
    else if (w_load) r_ptr <= w_gnt;
  end
`endif

  assign w_load = (r_state == S_IDLE) && w_gnt_vld;
  assign w_head = r_mem[w_gnt][r_rp[w_gnt][PW-1:0]];
  assign w_last = (r_cnt == BW'(NB - 1));
  assign w_adv  = (r_state == S_WAIT) &&
                  !bus.tx_busy && !w_last;
  assign w_shift_nx = r_shift >> 8;

  always_comb begin
    for (int j = 0; j < NUM_CH; j++) begin
      w_pop[j] = w_load && (w_gnt == CW'(j));
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_gnt_vld) w_next = S_START;
      S_START: w_next = S_GUARD;
      S_GUARD: w_next = S_WAIT;
      S_WAIT: begin
        if (!bus.tx_busy)
          w_next = w_last ? S_IDLE : S_START;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wp[c] <= '0;
        r_rp[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wp[c] <= r_wp[c] + P_ONE;
        if (w_pop[c])  r_rp[c] <= r_rp[c] + P_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c])
        r_mem[c][r_wp[c][PW-1:0]] <=
          bus.in_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_sdata <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_shift <= w_head;
        r_sdata <= w_head[7:0];
        r_cnt   <= '0;
        r_grant <= w_gnt;
      end else if (w_adv) begin
        r_shift <= w_shift_nx;
        r_sdata <= w_shift_nx[7:0];
        r_cnt   <= r_cnt + BW'(1);
      end
    end
  end

  assign bus.in_ready = ~w_full;
  assign bus.tx_start = (r_state == S_START);
  assign bus.sdata    = r_sdata;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_ch = r_grant;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner sequences and
// randomized traffic against a word-queue reference model.
module tb_uart_tx_arbiter;
  localparam int NCH   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NB    = DW / 8;

  logic clock = 1'b0;
  logic reset;

  uart_tx_arbiter_if #(.NUM_CH(NCH), .DATA_W(DW)) bus();

  uart_tx_arbiter #(
    .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    int         ch;
    int         cyc;
  } ev_t;

  typedef struct {
    int          ch;
    logic [31:0] w;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy_len = 3;
  bit rand_len = 0;
  bit force_busy = 0;

  logic [DW-1:0] mq [NCH][$];
  int            m_ptr = NCH - 1;
  bit            m_act = 0;
  logic [DW-1:0] m_word;
  int            m_idx, m_start, m_ch;
  int            m_acc = 0;
  ev_t           expq[$];
  ev_t           obs[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(
      input logic [DW-1:0] w, input int k);
    return 8'((w >> (8 * k)) & 'hFF);
  endfunction

  // reference model: word queues, one word in flight
  task automatic model_edge();
    bit acc [NCH];
    int pick;
    if (reset) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_ptr = NCH - 1;
      m_act = 0;
      expq.delete();
      return;
    end
    for (int c = 0; c < NCH; c++)
      acc[c] = bus.in_valid[c] && (mq[c].size() < DEPTH);
    if (!m_act) begin
      pick = -1;
`ifdef TX_ARB_PRIO_EN
      for (int c = NCH - 1; c >= 0; c--)
        if (mq[c].size() > 0) pick = c;
`else
      for (int k = NCH; k >= 1; k--)
        if (mq[(m_ptr + k) % NCH].size() > 0)
          pick = (m_ptr + k) % NCH;
`endif
      if (pick >= 0) begin
        m_ch    = pick;
        m_ptr   = pick;
        m_word  = mq[pick].pop_front();
        m_act   = 1;
        m_idx   = 0;
        m_start = cyc + 1;
        expq.push_back('{b: byte_of(m_word, 0),
                         ch: pick, cyc: cyc + 1});
      end
    end else if (cyc >= m_start + 2 && !bus.tx_busy) begin
      if (m_idx == NB - 1) begin
        m_act = 0;
      end else begin
        m_idx++;
        m_start = cyc + 1;
        expq.push_back('{b: byte_of(m_word, m_idx),
                         ch: m_ch, cyc: cyc + 1});
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        mq[c].push_back(bus.in_data[c*DW +: DW]);
        m_acc++;
      end
    end
  endtask

  task automatic monitor();
    logic [NCH-1:0] er;
    ev_t e;
    for (int c = 0; c < NCH; c++)
      er[c] = (mq[c].size() < DEPTH);
    check("in_ready", 32'(bus.in_ready), 32'(er));
    check("busy", 32'(bus.busy), 32'(m_act));
    if (bus.tx_start === 1'b1) begin
      obs.push_back('{b: bus.sdata,
                      ch: int'(bus.grant_ch), cyc: cyc});
      if (expq.size() == 0) begin
        check("unexpected_start_cyc", cyc, 0);
      end else begin
        e = expq.pop_front();
        check("start_cyc", cyc, e.cyc);
        check("sdata", 32'(bus.sdata), 32'(e.b));
        check("grant_ch", 32'(bus.grant_ch), e.ch);
      end
    end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
      check("tx_start", 32'(bus.tx_start), 1);
      void'(expq.pop_front());
    end
    if (bus.tx_start === 1'b1)
      busy_cnt = rand_len ? $urandom_range(0, 5) : busy_len;
    else if (busy_cnt > 0)
      busy_cnt--;
    bus.tx_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    cyc++;
    @(negedge clock);
    monitor();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push1(input int ch, input logic [31:0] w);
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*DW +: DW] = w;
    step();
    bus.in_valid = '0;
  endtask

  task automatic drain(input int maxc);
    int n;
    bit idle;
    n = 0;
    idle = 0;
    while (!idle && n < maxc) begin
      step();
      n++;
      idle = !m_act && (bus.busy == 1'b0);
      for (int c = 0; c < NCH; c++)
        if (mq[c].size() > 0) idle = 0;
    end
    if (!idle) check("drain_timeout_busy", 32'(bus.busy), 0);
  endtask

  vec_t        tv [4];
  logic [31:0] ew [3];
  int          ec [3];
  logic [7:0]  ab [8];
  int          t, r, a, n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    tv[0] = '{0, 32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
    tv[1] = '{1, 32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tv[2] = '{0, 32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[3] = '{1, 32'hFFFF0180, 8'h80, 8'h01, 8'hFF, 8'hFF};

    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.tx_busy  = 1'b0;
    reset = 1'b1;
    steps(2);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_sdata", 32'(bus.sdata), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_grant_ch", 32'(bus.grant_ch), 0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h3);
    reset = 1'b0;
    step();

    // single words from the vector table
    for (int v = 0; v < 4; v++) begin
      obs.delete();
      t = cyc;
      push1(tv[v].ch, tv[v].w);
      drain(100);
      check("vec_count", obs.size(), 4);
      if (obs.size() >= 4) begin
        check("vec_b0", 32'(obs[0].b), 32'(tv[v].e0));
        check("vec_b1", 32'(obs[1].b), 32'(tv[v].e1));
        check("vec_b2", 32'(obs[2].b), 32'(tv[v].e2));
        check("vec_b3", 32'(obs[3].b), 32'(tv[v].e3));
        check("vec_ch", obs[0].ch, tv[v].ch);
        for (int k = 0; k < 4; k++)
          check("vec_cyc", obs[k].cyc, t + 2 + 4 * k);
      end
      steps(3);
    end

    // round-robin vs priority order
    do_reset();
    obs.delete();
    bus.in_valid = 2'b11;
    bus.in_data  = {32'hB0B0B0B0, 32'hA0A0A0A0};
    step();
    bus.in_valid = 2'b01;
    bus.in_data  = {32'h0, 32'hA1A1A1A1};
    step();
    bus.in_valid = '0;
    drain(200);
`ifdef TX_ARB_PRIO_EN
    ew = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hB0B0B0B0};
    ec = '{0, 0, 1};
`else
    ew = '{32'hA0A0A0A0, 32'hB0B0B0B0, 32'hA1A1A1A1};
    ec = '{0, 1, 0};
`endif
    check("rr_count", obs.size(), 12);
    if (obs.size() >= 12) begin
      for (int i = 0; i < 3; i++) begin
        check("rr_ch", obs[4*i].ch, ec[i]);
        for (int j = 0; j < 4; j++)
          check("rr_byte", 32'(obs[4*i+j].b),
                32'(byte_of(ew[i], j)));
      end
      check("gap_in_word", obs[1].cyc - obs[0].cyc, 4);
      check("gap_x_word", obs[4].cyc - obs[3].cyc, 5);
    end

    // full FIFO with tx_busy held high
    do_reset();
    obs.delete();
    force_busy = 1'b1;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid[1] = 1'b1;
      bus.in_data[DW +: DW] = 32'h10000000 + i;
      n = 0;
      while (!bus.in_ready[1] && n < 20) begin
        step();
        n++;
      end
      step();
    end
    check("full_ready", 32'(bus.in_ready[1]), 0);
    bus.in_data[DW +: DW] = 32'h10000005;
    for (int i = 0; i < 8; i++) begin
      step();
      check("full_hold", 32'(bus.in_ready[1]), 0);
    end
    check("full_one_start", obs.size(), 1);
    r = cyc;
    force_busy = 1'b0;
    bus.tx_busy = 1'b0;
    a = -1;
    for (int i = 0; i < 40 && a < 0; i++) begin
      if (bus.in_ready[1]) a = cyc;
      else step();
    end
    check("full_accept_cyc", a, r + 14);
    step();
    bus.in_valid = '0;
    drain(500);
    check("full_total", obs.size(), 24);
    if (obs.size() >= 24)
      check("full_last", 32'(obs[20].b), 32'h05);

    // atomicity: ch1 arrives mid-word
    do_reset();
    obs.delete();
    t = cyc;
    push1(0, 32'h04030201);
    while (cyc < t + 7) step();
    push1(1, 32'hDEADBEEF);
    drain(200);
    ab = '{8'h01, 8'h02, 8'h03, 8'h04,
           8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check("atom_count", obs.size(), 8);
    if (obs.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        check("atom_byte", 32'(obs[k].b), 32'(ab[k]));
        check("atom_ch", obs[k].ch, k / 4);
      end
    end

    // reset in the middle of a word
    do_reset();
    obs.delete();
    t = cyc;
    bus.in_valid = 2'b11;
    bus.in_data  = {32'h1A1B1C1D, 32'h0A0B0C0D};
    step();
    bus.in_valid = 2'b01;
    bus.in_data  = {32'h0, 32'h2A2B2C2D};
    step();
    bus.in_valid = '0;
    while (cyc < t + 7) step();
    do_reset();
    check("mid_tx_start", 32'(bus.tx_start), 0);
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_in_ready", 32'(bus.in_ready), 32'h3);
    n = obs.size();
    steps(20);
    check("mid_quiet", obs.size(), n);
    bus.in_valid = 2'b11;
    bus.in_data  = {32'h3A3B3C3D, 32'h4A4B4C4D};
    step();
    bus.in_valid = '0;
    drain(200);
    check("mid_new", obs.size(), n + 8);
    if (obs.size() >= n + 8) begin
      check("mid_first_ch", obs[n].ch, 0);
      check("mid_first_b", 32'(obs[n].b), 32'h4D);
      check("mid_second_ch", obs[n+4].ch, 1);
    end

    // randomized traffic and UartTx busy lengths
    do_reset();
    obs.delete();
    m_acc = 0;
    rand_len = 1;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        bus.in_valid[c] = ($urandom_range(0, 3) == 0);
        bus.in_data[c*DW +: DW] = $urandom;
      end
      step();
    end
    bus.in_valid = '0;
    drain(4000);
    steps(8);
    rand_len = 0;
    check("rand_bytes", obs.size(), NB * m_acc);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
